// File: rtl/cabac_pkg.sv
// Shared definitions for the CABAC bitstream refill stage.
//   BIN_WIDTH_DEF / FIFO_DEPTH_DEF : default parameter values for the top
//   BITS_NEEDED_INIT               : bits_needed value after reset and after init (-8)
//   refill_state_t                 : refill sequencer states
package cabac_pkg;
    localparam int BIN_WIDTH_DEF  = 3;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int BYTE_W         = 8;
    localparam int BN_W           = 4;
    localparam int CB_W           = 3;
    localparam int TMP_W          = 5;

    localparam logic signed [BN_W-1:0] BITS_NEEDED_INIT = 4'sb1000;  // -8

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_INIT = 2'd2,
        ST_RUN  = 2'd3
    } refill_state_t;
endpackage

// File: rtl/cabac_bitstream_refill_byte_fifo.sv
// Synchronous byte FIFO for the refill stage.
//   push/push_data : write one entry
//   pop_cnt        : entries removed this cycle (0, 1 or 2)
//   count          : current occupancy (0..DEPTH)
//   head/head_next : oldest and second-oldest entries
// DEPTH must be a power of two so the pointers wrap naturally.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic [1:0]               pop_cnt,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         head_next
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr_nxt;

    assign rd_ptr_nxt = rd_ptr + 1'b1;
    assign head       = mem[rd_ptr];
    assign head_next  = mem[rd_ptr_nxt];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr + AW'(pop_cnt);
            count  <= count + CW'(push) - CW'(pop_cnt);
        end
    end
endmodule

// File: rtl/cabac_bitstream_refill.sv
// Byte-refill stage for the CABAC arithmetic decoder.
//   clk, reset(active-low async)
//   start                      : begin slice, re-initialise m_value from next two bytes
//   byte_req/byte_in/byte_ready: byte source handshake (one req per byte)
//   consume/consume_bits       : decoder advance and bits shifted out this cycle
//   stall                      : refill due but no byte buffered
//   init_valid/init_value      : {byte0,byte1} for m_value at slice start
//   refill_en/byte/shift/lane  : byte to add into m_value and where
//   bits_needed                : signed bit counter, -8..-1
//
// state | meaning
// IDLE  | no slice active, no byte requests
// FILL  | waiting for two buffered bytes
// INIT  | init_value presented, two bytes popped
// RUN   | decoding, refills on demand
import cabac_pkg::*;

module cabac_bitstream_refill #(
    parameter int BIN_WIDTH  = BIN_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   byte_req,
    input  logic [7:0]             byte_in,
    input  logic                   byte_ready,
    input  logic                   consume,
    input  logic [2:0]             consume_bits,
    output logic                   stall,
    output logic                   init_valid,
    output logic [15:0]            init_value,
    output logic                   refill_en,
    output logic [7:0]             refill_byte,
    output logic [2:0]             refill_shift,
    output logic [BIN_WIDTH-1:0]   refill_lane,
    output logic signed [3:0]      bits_needed
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    refill_state_t        state;
    logic [CW-1:0]        fifo_cnt;
    logic [CW-1:0]        outstanding;
    logic [7:0]           head;
    logic [7:0]           head_next;
    logic                 fifo_empty;
    logic                 push;
    logic [1:0]           pop_cnt;
    logic [TMP_W-1:0]     tmp;
    logic                 need;
    logic [BN_W-1:0]      lane_idx;

    byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BYTE_W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (byte_in),
        .pop_cnt   (pop_cnt),
        .count     (fifo_cnt),
        .head      (head),
        .head_next (head_next)
    );

    assign fifo_empty = (fifo_cnt == '0);
    assign byte_req   = (state != ST_IDLE) &&
                        ((CW+1)'(fifo_cnt) + (CW+1)'(outstanding) < (CW+1)'(FIFO_DEPTH));
    // A ready with nothing outstanding answers a request issued before reset.
    assign push       = byte_ready && (outstanding != '0);

    assign tmp        = {bits_needed[BN_W-1], bits_needed} + {2'b00, consume_bits};
    assign need       = (state == ST_RUN) && consume && !tmp[TMP_W-1];
    assign stall      = need && fifo_empty;
    assign refill_en  = need && !fifo_empty;
    assign refill_byte  = refill_en ? head : '0;
    assign refill_shift = refill_en ? tmp[2:0] : '0;
    assign pop_cnt    = (state == ST_INIT) ? 2'd2 : {1'b0, refill_en};

    // -bits_needed-1 is the bitwise complement in two's complement.
    assign lane_idx   = ~bits_needed;

    always_comb begin
        refill_lane = '0;
        for (int i = 0; i < BIN_WIDTH; i++)
            refill_lane[i] = refill_en && (int'(lane_idx) == i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            outstanding <= '0;
            bits_needed <= BITS_NEEDED_INIT;
            init_valid  <= 1'b0;
            init_value  <= '0;
        end else begin
            outstanding <= outstanding + CW'(byte_req) - CW'(push);
            init_valid  <= 1'b0;
            case (state)
                ST_IDLE: if (start) state <= ST_FILL;
                ST_FILL: begin
                    if (fifo_cnt >= CW'(2)) begin
                        state      <= ST_INIT;
                        init_valid <= 1'b1;
                        init_value <= {head, head_next};
                    end
                end
                ST_INIT: begin
                    bits_needed <= BITS_NEEDED_INIT;
                    state       <= ST_RUN;
                end
                ST_RUN: begin
                    if (consume && !stall)
                        bits_needed <= need ? BN_W'(tmp - 5'd8) : BN_W'(tmp);
                    if (start) state <= ST_FILL;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cabac_bitstream_refill.sv
// Self-checking bench for cabac_bitstream_refill: directed scenarios plus a
// randomized byte source, compared cycle by cycle with a queue-based model.
module tb_cabac_bitstream_refill;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_req;
    logic [7:0]  byte_in;
    logic        byte_ready;
    logic        consume;
    logic [2:0]  consume_bits;
    logic        stall;
    logic        init_valid;
    logic [15:0] init_value;
    logic        refill_en;
    logic [7:0]  refill_byte;
    logic [2:0]  refill_shift;
    logic [2:0]  refill_lane;
    logic signed [3:0] bits_needed;

    always #5 clk = ~clk;

    cabac_bitstream_refill #(.BIN_WIDTH(3), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_req     (byte_req),
        .byte_in      (byte_in),
        .byte_ready   (byte_ready),
        .consume      (consume),
        .consume_bits (consume_bits),
        .stall        (stall),
        .init_valid   (init_valid),
        .init_value   (init_value),
        .refill_en    (refill_en),
        .refill_byte  (refill_byte),
        .refill_shift (refill_shift),
        .refill_lane  (refill_lane),
        .bits_needed  (bits_needed)
    );

    localparam int M_IDLE = 0, M_FILL = 1, M_INIT = 2, M_RUN = 3;

    int errors = 0;
    int checks = 0;

    // reference model
    int         m_state;
    int         m_bn;
    logic [7:0] m_fifo[$];
    int         req_age[$];
    logic [7:0] src_data[$];
    int         stale;
    int         delay_min;
    bit         starve;

    // observations kept for directed checks
    bit          init_seen;
    logic [15:0] init_seen_val;
    logic        last_ref, last_stall;
    logic [2:0]  last_shift, last_lane;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_byte_req",     32'(byte_req), 32'd0);
        chk("rst_stall",        32'(stall), 32'd0);
        chk("rst_init_valid",   32'(init_valid), 32'd0);
        chk("rst_init_value",   32'(init_value), 32'd0);
        chk("rst_refill_en",    32'(refill_en), 32'd0);
        chk("rst_refill_byte",  32'(refill_byte), 32'd0);
        chk("rst_refill_shift", 32'(refill_shift), 32'd0);
        chk("rst_refill_lane",  32'(refill_lane), 32'd0);
        chk("rst_bits_needed",  {28'd0, bits_needed}, 32'h8);
    endtask

    task automatic model_reset();
        stale = req_age.size();
        req_age.delete();
        m_fifo.delete();
        m_state = M_IDLE;
        m_bn    = -8;
    endtask

    // One clock cycle: drive at negedge, check at negedge+1, update model at posedge.
    task automatic step(input bit cons, input int cb, input bit st);
        bit deliver, junk, exp_req, exp_need, exp_stall, exp_ref;
        int tmp, sz_before, lane_exp;
        logic [7:0] b;
        @(negedge clk);
        deliver = 1'b0;
        junk    = 1'b0;
        b       = 8'($urandom);
        if (stale > 0 && m_state == M_IDLE && !st)
            junk = 1'b1;
        else if (!starve && req_age.size() > 0 && req_age[0] >= delay_min &&
                 ($urandom_range(0, 3) != 0 || req_age[0] >= delay_min + 3)) begin
            deliver = 1'b1;
            if (src_data.size() > 0) begin
                b = src_data[0];
                src_data.delete(0);
            end
        end
        byte_ready   = deliver | junk;
        byte_in      = b;
        consume      = cons;
        consume_bits = 3'(cb);
        start        = st;
        #1;
        last_ref   = refill_en;
        last_stall = stall;
        last_shift = refill_shift;
        last_lane  = refill_lane;
        if (init_valid === 1'b1) begin
            init_seen     = 1'b1;
            init_seen_val = init_value;
        end
        exp_req = (m_state != M_IDLE) && (m_fifo.size() + req_age.size() < 4);
        chk("byte_req", 32'(byte_req), 32'(exp_req));
        chk("init_valid", 32'(init_valid), 32'(m_state == M_INIT));
        if (m_state == M_INIT)
            chk("init_value", 32'(init_value), {16'd0, m_fifo[0], m_fifo[1]});
        tmp       = m_bn + cb;
        exp_need  = (m_state == M_RUN) && cons && (tmp >= 0);
        exp_stall = exp_need && (m_fifo.size() == 0);
        exp_ref   = exp_need && (m_fifo.size() > 0);
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("refill_en", 32'(refill_en), 32'(exp_ref));
        if (exp_ref) begin
            lane_exp = (-m_bn <= 3) ? (1 << (-m_bn - 1)) : 0;
            chk("refill_byte", 32'(refill_byte), 32'(m_fifo[0]));
            chk("refill_shift", 32'(refill_shift), 32'(tmp));
            chk("refill_lane", 32'(refill_lane), 32'(lane_exp));
        end
        chk("bits_needed", {28'd0, bits_needed}, {28'd0, 4'(m_bn)});
        @(posedge clk);
        sz_before = m_fifo.size();
        if (junk) stale--;
        if (deliver) begin
            req_age.delete(0);
            m_fifo.push_back(b);
        end
        if (exp_req) req_age.push_back(0);
        foreach (req_age[i]) req_age[i]++;
        case (m_state)
            M_IDLE: if (st) m_state = M_FILL;
            M_FILL: if (sz_before >= 2) m_state = M_INIT;
            M_INIT: begin
                m_fifo.delete(0);
                m_fifo.delete(0);
                m_bn    = -8;
                m_state = M_RUN;
            end
            default: begin
                if (exp_ref) m_fifo.delete(0);
                if (cons && !exp_stall) m_bn = exp_need ? tmp - 8 : tmp;
                if (st) m_state = M_FILL;
            end
        endcase
    endtask

    task automatic peek_bn(input string tag, input int exp);
        #1 chk(tag, {28'd0, bits_needed}, {28'd0, 4'(exp)});
    endtask

    initial begin
        logic [3:0] bn_hold;
        reset = 1'b0; start = 1'b0; byte_ready = 1'b0; byte_in = '0;
        consume = 1'b0; consume_bits = '0;
        stale = 0; delay_min = 1; starve = 1'b0; init_seen = 1'b0;
        model_reset();
        @(negedge clk);
        chk_reset_outputs();
        @(negedge clk);
        reset = 1'b1;

        // 1: slice start, init from A5,3C
        src_data.push_back(8'hA5);
        src_data.push_back(8'h3C);
        step(0, 0, 1);
        for (int i = 0; i < 30 && m_state != M_RUN; i++) step(0, 0, 0);
        chk("t1_init_seen", 32'(init_seen), 32'd1);
        chk("t1_init_value", 32'(init_seen_val), 32'hA53C);
        peek_bn("t1_bn", -8);
        for (int i = 0; i < 6; i++) step(0, 0, 0);

        // 2: bypass-style consumes of 3 bits
        step(1, 3, 0); peek_bn("t2_bn_a", -5);
        step(1, 3, 0); peek_bn("t2_bn_b", -2);
        step(1, 3, 0);
        chk("t2_refill_en", 32'(last_ref), 32'd1);
        chk("t2_shift", 32'(last_shift), 32'd1);
        chk("t2_lane", 32'(last_lane), 32'b010);
        peek_bn("t2_bn_c", -7);

        // 3: regular consume reaching bits_needed=-1, then 7 bits
        step(1, 6, 0); peek_bn("t3_bn_a", -1);
        step(1, 7, 0);
        chk("t3_refill_en", 32'(last_ref), 32'd1);
        chk("t3_shift", 32'(last_shift), 32'd6);
        chk("t3_lane", 32'(last_lane), 32'b001);
        peek_bn("t3_bn_b", -2);

        // 4: starve the source until the decoder stalls
        starve = 1'b1;
        for (int i = 0; i < 16 && m_fifo.size() > 0; i++) step(1, 7, 0);
        last_stall = 1'b0;
        for (int i = 0; i < 4 && last_stall !== 1'b1; i++) step(1, 7, 0);
        chk("t4_stall", 32'(last_stall), 32'd1);
        bn_hold = 4'(m_bn);
        step(1, 7, 0);
        chk("t4_stall_hold", 32'(last_stall), 32'd1);
        #1 chk("t4_bn_hold", {28'd0, bits_needed}, {28'd0, bn_hold});
        starve = 1'b0;
        step(1, 7, 0);
        step(1, 7, 0);
        chk("t4_refill_after", 32'(last_ref), 32'd1);
        chk("t4_stall_clear", 32'(last_stall), 32'd0);

        // 5: slow source, then fully random traffic with occasional restarts
        delay_min = 3;
        for (int i = 0; i < 60; i++) step($urandom_range(0, 1), $urandom_range(1, 7), 0);
        for (int i = 0; i < 300; i++) begin
            delay_min = $urandom_range(1, 4);
            step($urandom_range(0, 3) != 0, $urandom_range(1, 7), $urandom_range(0, 49) == 0);
        end

        // 6: reset with requests in flight, then clean restart
        for (int i = 0; i < 40 && m_state != M_RUN; i++) step(0, 0, 0);
        delay_min = 6;
        for (int i = 0; i < 20 && req_age.size() < 2; i++) step(1, 7, 0);
        @(negedge clk);
        byte_ready = 1'b0; consume = 1'b0; start = 1'b0;
        #2 reset = 1'b0;
        #1 chk_reset_outputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6 && stale > 0; i++) step(0, 0, 0);
        src_data.delete();
        src_data.push_back(8'h12);
        src_data.push_back(8'h34);
        delay_min = 1;
        init_seen = 1'b0;
        step(0, 0, 1);
        for (int i = 0; i < 30 && m_state != M_RUN; i++) step(0, 0, 0);
        chk("t6_init_seen", 32'(init_seen), 32'd1);
        chk("t6_init_value", 32'(init_seen_val), 32'h1234);
        peek_bn("t6_bn", -8);
        for (int i = 0; i < 40; i++) step($urandom_range(0, 1), $urandom_range(1, 7), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
